alu_op_sequencer: RTL and testbench

- Multi-cycle control stage directly upstream and downstream of the 32-bit ALU.
- Accepts an operation request with two operands and drives the ALU's one-hot control word and X/Y operands for exactly one cycle.
- Captures the 64-bit ALU result into an internal Z register.
- Writes the result back to the datapath bus as one or two 32-bit words using a valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Control stage that sits on both sides of a 2*BITS-result ALU. It accepts one
// operation request at a time, drives the ALU's one-hot control word for
// exactly one cycle, captures the full ALU result into Z and then returns it
// to the datapath bus as one word (low half) or two words (low then high half
// for MUL and DIV) under a valid/ready handshake.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   clr        : synchronous active-high reset, overrides everything
//   start      : request strobe, looked at only while idle
//   op_sel     : binary op index 0..11 (2 = MUL, 3 = DIV produce two words)
//   opa / opb  : operands, latched on acceptance and presented as alu_x/alu_y
//   busy       : registered, high whenever the sequencer is not idle
//   alu_ctrl   : one-hot ALU control, non-zero only during the execute cycle
//   alu_result : combinational ALU result, sampled at the end of execute
//   bus_out    : writeback word, bus_hi marks the upper half of Z
//   bus_valid  : bus_out is valid; a word moves when bus_valid && bus_ready
//   done       : one-cycle pulse after the final word has been accepted
//   err        : one-cycle pulse for a rejected request (bad op, divide by 0)
module alu_op_sequencer #(
    parameter int BITS      = 32,
    parameter int SIG_COUNT = 12
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [3:0]            op_sel,
    input  logic [BITS-1:0]       opa,
    input  logic [BITS-1:0]       opb,
    output logic                  busy,
    output logic [SIG_COUNT-1:0]  alu_ctrl,
    output logic [BITS-1:0]       alu_x,
    output logic [BITS-1:0]       alu_y,
    input  logic [2*BITS-1:0]     alu_result,
    output logic [BITS-1:0]       bus_out,
    output logic                  bus_valid,
    output logic                  bus_hi,
    input  logic                  bus_ready,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_WB_LO = 2'd2,
        S_WB_HI = 2'd3
    } state_e;

    localparam logic [3:0]           OP_MUL  = 4'd2;
    localparam logic [3:0]           OP_DIV  = 4'd3;
    localparam logic [3:0]           OP_LAST = 4'd11;
    localparam logic [SIG_COUNT-1:0] CTRL_ONE = {{(SIG_COUNT-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [3:0]             op_q, op_d;
    logic [BITS-1:0]        x_q, x_d;
    logic [BITS-1:0]        y_q, y_d;
    logic [2*BITS-1:0]      z_q, z_d;
    logic                   busy_q, busy_d;
    logic [SIG_COUNT-1:0]   ctrl_q, ctrl_d;
    logic [BITS-1:0]        bus_out_q, bus_out_d;
    logic                   bus_valid_q, bus_valid_d;
    logic                   bus_hi_q, bus_hi_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   req_legal_s;
    logic                   accept_s;
    logic                   reject_s;
    logic                   two_word_s;
    logic                   last_hs_s;

    // A divide by zero is refused up front so the ALU is never asked for it.
    assign req_legal_s = (op_sel <= OP_LAST) &&
                         !((op_sel == OP_DIV) && (opb == {BITS{1'b0}}));
    assign two_word_s  = (op_q == OP_MUL) || (op_q == OP_DIV);

    // State and output registers; clr discards any operation in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            op_q        <= 4'd0;
            x_q         <= {BITS{1'b0}};
            y_q         <= {BITS{1'b0}};
            z_q         <= {(2*BITS){1'b0}};
            busy_q      <= 1'b0;
            ctrl_q      <= {SIG_COUNT{1'b0}};
            bus_out_q   <= {BITS{1'b0}};
            bus_valid_q <= 1'b0;
            bus_hi_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            busy_q      <= busy_d;
            ctrl_q      <= ctrl_d;
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
            bus_hi_q    <= bus_hi_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic; requests outside IDLE are simply not looked at.
    always_comb begin
        state_d   = state_q;
        accept_s  = 1'b0;
        reject_s  = 1'b0;
        last_hs_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && req_legal_s) begin
                    accept_s = 1'b1;
                    state_d  = S_EXEC;
                end else if (start) begin
                    reject_s = 1'b1;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_EXEC: begin
                state_d = S_WB_LO;
            end
            S_WB_LO: begin
                if (bus_ready && two_word_s) begin
                    state_d = S_WB_HI;
                end else if (bus_ready) begin
                    state_d   = S_IDLE;
                    last_hs_s = 1'b1;
                end else begin
                    state_d = S_WB_LO;
                end
            end
            S_WB_HI: begin
                if (bus_ready) begin
                    state_d   = S_IDLE;
                    last_hs_s = 1'b1;
                end else begin
                    state_d = S_WB_HI;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/datapath next values, computed from the upcoming state so that
    // every output comes straight from a flop.
    always_comb begin
        op_d        = accept_s ? op_sel : op_q;
        x_d         = accept_s ? opa    : x_q;
        y_d         = accept_s ? opb    : y_q;
        z_d         = (state_q == S_EXEC) ? alu_result : z_q;
        busy_d      = (state_d != S_IDLE);
        ctrl_d      = (state_d == S_EXEC) ? (CTRL_ONE << op_d) : {SIG_COUNT{1'b0}};
        bus_valid_d = (state_d == S_WB_LO) || (state_d == S_WB_HI);
        bus_hi_d    = (state_d == S_WB_HI);
        done_d      = last_hs_s;
        err_d       = reject_s;
        case (state_d)
            S_WB_LO: bus_out_d = z_d[BITS-1:0];
            S_WB_HI: bus_out_d = z_d[2*BITS-1:BITS];
            default: bus_out_d = {BITS{1'b0}};
        endcase
    end

    assign busy      = busy_q;
    assign alu_ctrl  = ctrl_q;
    assign alu_x     = x_q;
    assign alu_y     = y_q;
    assign bus_out   = bus_out_q;
    assign bus_valid = bus_valid_q;
    assign bus_hi    = bus_hi_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer. The bench plays the ALU with its
// own reference model; expected bus words are queued when a request is driven
// and popped by a monitor whenever a word is handed over on the bus.
module tb_alu_op_sequencer;

    localparam int BITS = 32;
    localparam int SIG  = 12;

    logic             clk = 1'b0;
    logic             clr;
    logic             start;
    logic [3:0]       op_sel;
    logic [BITS-1:0]  opa, opb;
    logic             busy;
    logic [SIG-1:0]   alu_ctrl;
    logic [BITS-1:0]  alu_x, alu_y;
    logic [2*BITS-1:0] alu_result;
    logic [BITS-1:0]  bus_out;
    logic             bus_valid, bus_hi, bus_ready;
    logic             done, err;

    alu_op_sequencer #(.BITS(BITS), .SIG_COUNT(SIG)) dut (
        .clk(clk), .clr(clr), .start(start), .op_sel(op_sel), .opa(opa), .opb(opb),
        .busy(busy), .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
        .alu_result(alu_result), .bus_out(bus_out), .bus_valid(bus_valid),
        .bus_hi(bus_hi), .bus_ready(bus_ready), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          stall;
        logic        legal;
        int          words;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic        hi;
    } word_t;

    word_t       exp_q[$];
    vec_t        tbl[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          ctrl_cnt, done_cnt, err_cnt, hs_cnt, valid_cnt, busy_cnt;
    logic [11:0] exp_ctrl;
    logic [31:0] last_x, last_y;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference ALU: MUL gives the full signed product, DIV gives {rem, quot}.
    function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] xa, xb, q, rm;
        logic signed [63:0] wa, wb;
        logic [63:0] dbl, r;
        logic [4:0]  sh;
        xa = a; xb = b;
        wa = 64'(xa); wb = 64'(xb);
        sh = b[4:0];
        dbl = {a, a};
        case (op)
            4'd0:  r = wa + wb;
            4'd1:  r = wa - wb;
            4'd2:  r = wa * wb;
            4'd3:  begin
                       if (b == 32'd0) begin
                           r = 64'd0;
                       end else begin
                           q = xa / xb; rm = xa % xb; r = {rm, q};
                       end
                   end
            4'd4:  r = {32'd0, a >> sh};
            4'd5:  r = {32'd0, a << sh};
            4'd6:  begin dbl = dbl >> sh; r = {32'd0, dbl[31:0]}; end
            4'd7:  begin dbl = dbl << sh; r = {32'd0, dbl[63:32]}; end
            4'd8:  r = {32'd0, a & b};
            4'd9:  r = {32'd0, a | b};
            4'd10: r = -wa;
            4'd11: r = ~wa;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Bench-side ALU; a recognisable junk value when not driven one-hot.
    always_comb begin
        alu_result = 64'hA5A5_5A5A_C3C3_3C3C;
        for (int i = 0; i < SIG; i++) begin
            if (alu_ctrl == (12'd1 << i)) alu_result = alu_ref(4'(i), alu_x, alu_y);
        end
    end

    // Monitor: pops the scoreboard on every bus handshake and counts events.
    always @(negedge clk) begin : mon
        word_t e;
        if (busy) busy_cnt++;
        if (bus_valid) valid_cnt++;
        if (alu_ctrl != 12'd0) begin
            ctrl_cnt++;
            check("alu_ctrl", 64'(alu_ctrl), 64'(exp_ctrl));
            check("busy_in_exec", 64'(busy), 64'd1);
        end
        if (bus_valid && bus_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_word: got %h hi=%0d expected no word", bus_out, bus_hi);
            end else begin
                e = exp_q.pop_front();
                check("bus_word", {31'd0, bus_hi, bus_out}, {31'd0, e.hi, e.w});
            end
        end
        if (done) begin
            done_cnt++;
            check("busy_low_with_done", 64'(busy), 64'd0);
        end
        if (err) err_cnt++;
        if (done || err) check("done_err_exclusive", 64'(done & err), 64'd0);
    end

    task automatic clear_counts();
        ctrl_cnt = 0; done_cnt = 0; err_cnt = 0; hs_cnt = 0; valid_cnt = 0; busy_cnt = 0;
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        int stall_left;
        clear_counts();
        exp_ctrl = 12'd1 << v.op;
        if (v.legal) begin
            exp_q.push_back('{v.lo, 1'b0});
            if (v.words == 2) exp_q.push_back('{v.hi, 1'b1});
        end
        stall_left = v.stall;
        bus_ready  = (v.stall == 0);
        op_sel = v.op; opa = v.a; opb = v.b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (v.legal) begin
            check("busy_after_accept", 64'(busy), 64'd1);
            check("alu_x_latched", 64'(alu_x), 64'(v.a));
            check("alu_y_latched", 64'(alu_y), 64'(v.b));
            last_x = v.a; last_y = v.b;
        end else begin
            check("err_pulse", 64'(err), 64'd1);
            check("busy_on_reject", 64'(busy), 64'd0);
            check("alu_x_kept", {last_y, last_x}, {alu_y, alu_x});
        end
        lat = 0;
        for (int i = 1; i <= 60 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (bus_valid && !bus_ready) begin
                check("held_word", {31'd0, bus_hi, bus_out}, {31'd0, 1'b0, v.lo});
                if (stall_left == 0) bus_ready = 1'b1;
                else stall_left--;
            end
            if (done) lat = i;
            if (!v.legal && i == 4) lat = -1;
        end
        repeat (2) begin @(posedge clk); #1; end
        if (v.legal) check("latency", 64'(lat), 64'(1 + v.words + v.stall));
        check("done_count", 64'(done_cnt), 64'(v.legal ? 1 : 0));
        check("err_count", 64'(err_cnt), 64'(v.legal ? 0 : 1));
        check("ctrl_cycles", 64'(ctrl_cnt), 64'(v.legal ? 1 : 0));
        check("word_count", 64'(hs_cnt), 64'(v.legal ? v.words : 0));
        if (!v.legal) check("no_valid_no_busy", 64'(valid_cnt + busy_cnt), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("idle_after", {62'd0, busy, bus_valid}, 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] pa[4];
        logic [31:0] pb[4];
        logic [63:0] r;
        vec_t        v;
        pa = '{32'd15, 32'hFFFF_FFF1, 32'd15, 32'hFFFF_FFF1};
        pb = '{32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB};

        // Directed rows with hand-computed results.
        tbl.push_back('{4'd0,  32'd15,        32'd5,         0, 1'b1, 1, 32'h0000_0014, 32'h0});
        tbl.push_back('{4'd2,  32'd15,        32'hFFFF_FFFB, 0, 1'b1, 2, 32'hFFFF_FFB5, 32'hFFFF_FFFF});
        tbl.push_back('{4'd3,  32'hFFFF_FFF1, 32'd5,         3, 1'b1, 2, 32'hFFFF_FFFD, 32'h0});
        tbl.push_back('{4'd12, 32'd15,        32'd5,         0, 1'b0, 0, 32'h0,         32'h0});
        tbl.push_back('{4'd3,  32'd15,        32'd0,         0, 1'b0, 0, 32'h0,         32'h0});
        tbl.push_back('{4'd15, 32'd7,         32'd9,         0, 1'b0, 0, 32'h0,         32'h0});
        tbl.push_back('{4'd8,  32'hF0F0_1234, 32'h0FF0_FF00, 2, 1'b1, 1, 32'h00F0_1200, 32'h0});
        // Sweep of every op with the four sign combinations of (15, 5).
        for (int op = 0; op < 12; op++) begin
            for (int k = 0; k < 4; k++) begin
                r = alu_ref(4'(op), pa[k], pb[k]);
                v = '{4'(op), pa[k], pb[k], (op + k) % 3, 1'b1,
                      ((op == 2) || (op == 3)) ? 2 : 1, r[31:0], r[63:32]};
                tbl.push_back(v);
            end
        end

        clr = 1'b1; start = 1'b0; op_sel = 4'd0; opa = 32'd0; opb = 32'd0; bus_ready = 1'b0;
        exp_ctrl = 12'd0; last_x = 32'd0; last_y = 32'd0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, alu_ctrl, bus_valid, bus_hi, done, err, bus_out}, 64'd0);
        check("reset_xy", {alu_y, alu_x}, 64'd0);
        clr = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) run_op(tbl[i]);

        // clr while the high MUL word waits; a start while busy must be dropped.
        clear_counts();
        exp_ctrl = 12'h004;
        exp_q.push_back('{32'hFFFF_FFB5, 1'b0});
        exp_q.push_back('{32'hFFFF_FFFF, 1'b1});
        bus_ready = 1'b0;
        op_sel = 4'd2; opa = 32'd15; opb = 32'hFFFF_FFFB; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("in_wb_lo", {62'd0, bus_valid, bus_hi}, 64'd2);
        op_sel = 4'd0; opa = 32'd1; opb = 32'd1; start = 1'b1; bus_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bus_ready = 1'b0;
        check("in_wb_hi", {62'd0, bus_valid, bus_hi}, 64'd3);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_outputs", {busy, alu_ctrl, bus_valid, bus_hi, done, err, bus_out}, 64'd0);
        check("clr_xy", {alu_y, alu_x}, 64'd0);
        last_x = 32'd0; last_y = 32'd0;
        check("clr_pending_words", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        repeat (5) begin @(posedge clk); #1; end
        check("clr_no_done", 64'(done_cnt + err_cnt), 64'd0);
        check("busy_start_ignored", 64'(ctrl_cnt), 64'd1);
        check("clr_word_count", 64'(hs_cnt), 64'd1);
        check("clr_idle", {62'd0, busy, bus_valid}, 64'd0);

        // Normal operation resumes after the mid-operation clear.
        run_op(tbl[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
